rr_arbiter_fsm: RTL

- Round-robin arbiter FSM that shares one resource (for example a shared DFFSR-based register bank or bus) among N requesters.
- Uses a req/gnt/done handshake with a bounded hold time.
- Sits between requester FSMs and the shared datapath; gates which requester drives the resource.
- Built from the team's delay-annotated cell flow after synthesis; the RTL itself is purely behavioural.

---
 rtl/rr_arbiter_fsm_pkg.sv | 16 +
 rtl/rr_arbiter_fsm_if.sv | 24 ++
 rtl/rr_arbiter_fsm_pick.sv | 32 +++
 rtl/rr_arbiter_fsm.sv | 115 +++++++++++
 4 files changed

// File: rtl/rr_arbiter_fsm_pkg.sv
// Shared definitions for the round-robin arbiter.
//   state_t      : FSM state encoding (2'b11 is illegal, recovers to IDLE)
//   HOLD_MAX_DEF : default maximum grant hold, in cycles
//   CNT_W        : hold counter width
package rr_arbiter_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_RELEASE = 2'b10
  } state_t;

  localparam int HOLD_MAX_DEF = 8;
  localparam int CNT_W        = 4;

endpackage

// File: rtl/rr_arbiter_fsm_if.sv
// Requester-side handshake bundle for rr_arbiter_fsm.
//   req     : per-requester level request
//   done    : single-cycle completion pulse from the current holder
//   gnt     : one-hot registered grant
//   gnt_id  : index of current/last grantee
//   busy    : grant active
//   timeout : one-cycle pulse on forced release
// master = requester side, slave = arbiter side.
interface rr_arbiter_fsm_if
  import rr_arbiter_fsm_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic           done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;

  modport master (output req, done, input gnt, gnt_id, busy, timeout);
  modport slave  (input req, done, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/rr_arbiter_fsm_pick.sv
// rr_pick: rotate-and-priority-encode. Returns the first set bit of req
// searching ptr, ptr+1, ... wrapping modulo N.
//   req  : request vector
//   ptr  : starting index (assumed < N)
//   pick : selected index (0 when any=0)
//   any  : at least one request set
module rr_pick
  import rr_arbiter_fsm_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] pick,
  output logic           any
);

  logic [IDW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = |req;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr) + i) % N);
      if (req[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter sharing one resource among N requesters with a
// req/gnt/done handshake and a bounded hold time.
//   C   : clock, rising edge
//   R   : asynchronous active-high reset
//   bus : handshake bundle (slave side); all outputs registered
module rr_arbiter_fsm
  import rr_arbiter_fsm_pkg::*;
#(
  parameter int N        = 4,
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int IDW      = 2
) (
  input  logic           C,
  input  logic           R,
  rr_arbiter_fsm_if.slave bus
);

  state_t             state_q, state_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_q, hold_d;

  logic [IDW-1:0]     pick;
  logic               any;
  logic               rel_done, rel_wd, rel_to;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req  (bus.req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  assign rel_done = bus.done;
  assign rel_wd   = ~bus.req[gnt_id_q];
  assign rel_to   = (hold_q == CNT_W'(HOLD_MAX - 1));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any) begin
          gnt_d    = N'(1) << pick;
          gnt_id_d = pick;
          busy_d   = 1'b1;
          hold_d   = '0;
          state_d  = ST_GRANT;
        end else begin
          gnt_d  = '0;
          busy_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (rel_done || rel_wd || rel_to) begin
          gnt_d     = '0;
          busy_d    = 1'b0;
          ptr_d     = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + 1'b1;
          // Forced release is only flagged when nothing else explains it.
          timeout_d = rel_to & ~rel_done & ~rel_wd;
          state_d   = ST_RELEASE;
        end else begin
          hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        // Dead cycle: keeps grants from landing on adjacent cycles.
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        busy_d   = 1'b0;
        hold_d   = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule
